// File: rtl/mips_pkg.sv
// Shared constants for the MIPS fetch stage: word size, reset PC and the NOP encoding.
package mips_pkg;

  // sll $0,$0,0 -- the canonical MIPS no-op
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Bytes per instruction word; PC advances by this amount
  localparam logic [31:0] WORD_BYTES = 32'd4;

  // Default PC value after reset
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  // Sequential successor of a PC, wrapping modulo 2^32
  function automatic logic [31:0] next_seq_pc(input logic [31:0] pc);
    return pc + WORD_BYTES;
  endfunction

  // Force a branch target onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & ~(WORD_BYTES - 32'd1);
  endfunction

endpackage

// File: rtl/if_stage_regs_if.sv
// Bundle of hazard-unit controls, instruction memory and IF/ID outputs of the fetch stage.
interface if_stage_regs_if #(
  parameter int CNT_W = 16
);
  logic             pc_write_i;
  logic             if_id_write_i;
  logic             flush_i;
  logic [31:0]      branch_target_i;
  logic [31:0]      instr_i;
  logic [31:0]      pc_o;
  logic [31:0]      if_id_pc4_o;
  logic [31:0]      if_id_instr_o;
  logic             if_id_valid_o;
  logic [CNT_W-1:0] stall_cnt_o;
  logic [CNT_W-1:0] flush_cnt_o;

  // Hazard unit / memory side: drives controls and instruction data, observes the stage
  modport master (
    output pc_write_i, if_id_write_i, flush_i, branch_target_i, instr_i,
    input  pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, stall_cnt_o, flush_cnt_o
  );

  // Fetch stage side
  modport slave (
    input  pc_write_i, if_id_write_i, flush_i, branch_target_i, instr_i,
    output pc_o, if_id_pc4_o, if_id_instr_o, if_id_valid_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/if_stage_regs_sat_counter.sv
// Saturating event counter: counts edges with inc_i high, sticks at all-ones, cleared only by reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_reg;

  // Count qualifying edges, holding once the maximum value is reached
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_reg <= '0;
    end else if (inc_i && (cnt_reg != {W{1'b1}})) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt_o = cnt_reg;
endmodule

// File: rtl/if_stage_regs.sv
// MIPS fetch stage: program counter, IF/ID pipeline register and stall/flush event counters.
module if_stage_regs
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int          CNT_W     = 16,
  parameter logic [31:0] NOP_INSTR = NOP_WORD
) (
  input logic            clk_i,
  input logic            rst_i,
  if_stage_regs_if.slave bus
);
  logic [31:0] pc_reg;
  logic [31:0] if_id_pc4_reg;
  logic [31:0] if_id_instr_reg;
  logic        if_id_valid_reg;
  logic [31:0] pc_plus4;
  logic        stall_event;
  logic        flush_event;

  assign pc_plus4    = next_seq_pc(pc_reg);
  assign flush_event = bus.flush_i;
  // A stall is only counted when no flush overrides it
  assign stall_event = !bus.flush_i && !bus.pc_write_i;

  // PC update: flush redirect beats the stall hold, otherwise sequential advance
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      pc_reg <= RESET_PC;
    end else if (bus.flush_i) begin
      pc_reg <= word_align(bus.branch_target_i);
    end else if (bus.pc_write_i) begin
      pc_reg <= pc_plus4;
    end
  end

  // IF/ID capture: flush inserts a bubble even when capture is disabled
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if_id_pc4_reg   <= '0;
      if_id_instr_reg <= NOP_INSTR;
      if_id_valid_reg <= 1'b0;
    end else if (bus.flush_i) begin
      if_id_pc4_reg   <= '0;
      if_id_instr_reg <= NOP_INSTR;
      if_id_valid_reg <= 1'b0;
    end else if (bus.if_id_write_i) begin
      if_id_pc4_reg   <= pc_plus4;
      if_id_instr_reg <= bus.instr_i;
      if_id_valid_reg <= 1'b1;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (stall_event),
    .cnt_o (bus.stall_cnt_o)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (flush_event),
    .cnt_o (bus.flush_cnt_o)
  );

  assign bus.pc_o          = pc_reg;
  assign bus.if_id_pc4_o   = if_id_pc4_reg;
  assign bus.if_id_instr_o = if_id_instr_reg;
  assign bus.if_id_valid_o = if_id_valid_reg;
endmodule

// File: tb/tb_if_stage_regs.sv
// Directed testbench for if_stage_regs: default instance for flow/stall/flush, a second for wrap and saturation.
module tb_if_stage_regs;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  if_stage_regs_if #(.CNT_W(16)) bus_a ();
  if_stage_regs_if #(.CNT_W(4))  bus_b ();

  if_stage_regs u_dut_a (
    .clk_i (clk),
    .rst_i (rst_a),
    .bus   (bus_a.slave)
  );

  if_stage_regs #(.RESET_PC(32'hFFFF_FFF8), .CNT_W(4), .NOP_INSTR(32'h0000_0000)) u_dut_b (
    .clk_i (clk),
    .rst_i (rst_b),
    .bus   (bus_b.slave)
  );

  // Instruction memory model: the word at address p is C3 followed by the low 24 address bits
  function automatic logic [31:0] mem(input logic [31:0] p);
    return {8'hC3, p[23:0]};
  endfunction

  assign bus_a.instr_i = mem(bus_a.pc_o);
  assign bus_b.instr_i = mem(bus_b.pc_o);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle and log the observed state
  task automatic step();
    @(posedge clk);
    #1;
    $display("txn t=%0t A: pc=%h pc4=%h ins=%h v=%b st=%0d fl=%0d | B: pc=%h st=%0d",
             $time, bus_a.pc_o, bus_a.if_id_pc4_o, bus_a.if_id_instr_o, bus_a.if_id_valid_o,
             bus_a.stall_cnt_o, bus_a.flush_cnt_o, bus_b.pc_o, bus_b.stall_cnt_o);
  endtask

  task automatic test_reset();
    rst_a = 1'b0;
    bus_a.pc_write_i = 1'b1; bus_a.if_id_write_i = 1'b1;
    bus_a.flush_i = 1'b0; bus_a.branch_target_i = 32'h80;
    step();
    bus_a.flush_i = 1'b1;
    step();
    checks++; if (bus_a.pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc act=%h exp=%h", bus_a.pc_o, 32'h0); end
    checks++; if (bus_a.if_id_pc4_o !== 32'h0) begin errors++; $display("FAIL reset_pc4 act=%h exp=%h", bus_a.if_id_pc4_o, 32'h0); end
    checks++; if (bus_a.if_id_instr_o !== 32'h0) begin errors++; $display("FAIL reset_instr act=%h exp=%h", bus_a.if_id_instr_o, 32'h0); end
    checks++; if (bus_a.if_id_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid act=%b exp=0", bus_a.if_id_valid_o); end
    checks++; if (bus_a.stall_cnt_o !== 16'd0 || bus_a.flush_cnt_o !== 16'd0) begin errors++; $display("FAIL reset_cnt act=%0d/%0d exp=0/0", bus_a.stall_cnt_o, bus_a.flush_cnt_o); end
  endtask

  task automatic test_flow();
    bus_a.flush_i = 1'b0;
    rst_a = 1'b1;
    step();
    checks++; if (bus_a.pc_o !== 32'h4) begin errors++; $display("FAIL flow_pc1 act=%h exp=%h", bus_a.pc_o, 32'h4); end
    checks++; if (bus_a.if_id_valid_o !== 1'b1) begin errors++; $display("FAIL flow_valid1 act=%b exp=1", bus_a.if_id_valid_o); end
    checks++; if (bus_a.if_id_instr_o !== mem(32'h0)) begin errors++; $display("FAIL flow_instr1 act=%h exp=%h", bus_a.if_id_instr_o, mem(32'h0)); end
    step();
    checks++; if (bus_a.pc_o !== 32'h8) begin errors++; $display("FAIL flow_pc2 act=%h exp=%h", bus_a.pc_o, 32'h8); end
    checks++; if (bus_a.if_id_instr_o !== mem(32'h4) || bus_a.if_id_pc4_o !== 32'h8) begin errors++; $display("FAIL flow_ifid2 act=%h/%h exp=%h/%h", bus_a.if_id_instr_o, bus_a.if_id_pc4_o, mem(32'h4), 32'h8); end
  endtask

  task automatic test_stall();
    bus_a.pc_write_i = 1'b0; bus_a.if_id_write_i = 1'b0;
    step();
    checks++; if (bus_a.pc_o !== 32'h8) begin errors++; $display("FAIL stall_pc act=%h exp=%h", bus_a.pc_o, 32'h8); end
    checks++; if (bus_a.if_id_instr_o !== mem(32'h4) || bus_a.if_id_pc4_o !== 32'h8 || bus_a.if_id_valid_o !== 1'b1) begin errors++; $display("FAIL stall_ifid act=%h/%h/%b exp=%h/%h/1", bus_a.if_id_instr_o, bus_a.if_id_pc4_o, bus_a.if_id_valid_o, mem(32'h4), 32'h8); end
    checks++; if (bus_a.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL stall_cnt act=%0d exp=1", bus_a.stall_cnt_o); end
    bus_a.pc_write_i = 1'b1; bus_a.if_id_write_i = 1'b1;
    step();
    checks++; if (bus_a.pc_o !== 32'hC || bus_a.if_id_instr_o !== mem(32'h8) || bus_a.if_id_pc4_o !== 32'hC) begin errors++; $display("FAIL stall_resume act=%h/%h/%h exp=%h/%h/%h", bus_a.pc_o, bus_a.if_id_instr_o, bus_a.if_id_pc4_o, 32'hC, mem(32'h8), 32'hC); end
  endtask

  task automatic test_branch();
    bus_a.flush_i = 1'b1; bus_a.branch_target_i = 32'h40;
    step();
    checks++; if (bus_a.pc_o !== 32'h40) begin errors++; $display("FAIL branch_pc act=%h exp=%h", bus_a.pc_o, 32'h40); end
    checks++; if (bus_a.if_id_instr_o !== 32'h0 || bus_a.if_id_valid_o !== 1'b0 || bus_a.if_id_pc4_o !== 32'h0) begin errors++; $display("FAIL branch_bubble act=%h/%b/%h exp=0/0/0", bus_a.if_id_instr_o, bus_a.if_id_valid_o, bus_a.if_id_pc4_o); end
    checks++; if (bus_a.flush_cnt_o !== 16'd1 || bus_a.stall_cnt_o !== 16'd1) begin errors++; $display("FAIL branch_cnt act=%0d/%0d exp=1/1", bus_a.flush_cnt_o, bus_a.stall_cnt_o); end
    bus_a.flush_i = 1'b0;
    step();
    checks++; if (bus_a.pc_o !== 32'h44 || bus_a.if_id_instr_o !== mem(32'h40) || bus_a.if_id_pc4_o !== 32'h44 || bus_a.if_id_valid_o !== 1'b1) begin errors++; $display("FAIL branch_target_ifid act=%h/%h/%h/%b exp=%h/%h/%h/1", bus_a.pc_o, bus_a.if_id_instr_o, bus_a.if_id_pc4_o, bus_a.if_id_valid_o, 32'h44, mem(32'h40), 32'h44); end
  endtask

  task automatic test_flush_over_stall();
    bus_a.flush_i = 1'b1; bus_a.pc_write_i = 1'b0; bus_a.if_id_write_i = 1'b0;
    bus_a.branch_target_i = 32'h23;
    step();
    checks++; if (bus_a.pc_o !== 32'h20) begin errors++; $display("FAIL fs_pc act=%h exp=%h", bus_a.pc_o, 32'h20); end
    checks++; if (bus_a.if_id_valid_o !== 1'b0 || bus_a.if_id_instr_o !== 32'h0) begin errors++; $display("FAIL fs_bubble act=%b/%h exp=0/0", bus_a.if_id_valid_o, bus_a.if_id_instr_o); end
    checks++; if (bus_a.stall_cnt_o !== 16'd1 || bus_a.flush_cnt_o !== 16'd2) begin errors++; $display("FAIL fs_cnt act=%0d/%0d exp=1/2", bus_a.stall_cnt_o, bus_a.flush_cnt_o); end
    bus_a.flush_i = 1'b0; bus_a.pc_write_i = 1'b1; bus_a.if_id_write_i = 1'b1;
    step();
    checks++; if (bus_a.pc_o !== 32'h24 || bus_a.if_id_instr_o !== mem(32'h20) || bus_a.if_id_pc4_o !== 32'h24) begin errors++; $display("FAIL fs_resume act=%h/%h/%h exp=%h/%h/%h", bus_a.pc_o, bus_a.if_id_instr_o, bus_a.if_id_pc4_o, 32'h24, mem(32'h20), 32'h24); end
  endtask

  task automatic test_mismatched_enables();
    bus_a.pc_write_i = 1'b1; bus_a.if_id_write_i = 1'b0;
    step();
    checks++; if (bus_a.pc_o !== 32'h28 || bus_a.if_id_instr_o !== mem(32'h20) || bus_a.if_id_pc4_o !== 32'h24) begin errors++; $display("FAIL mm_pc_only act=%h/%h/%h exp=%h/%h/%h", bus_a.pc_o, bus_a.if_id_instr_o, bus_a.if_id_pc4_o, 32'h28, mem(32'h20), 32'h24); end
    bus_a.pc_write_i = 1'b0; bus_a.if_id_write_i = 1'b1;
    step();
    checks++; if (bus_a.pc_o !== 32'h28 || bus_a.if_id_instr_o !== mem(32'h28) || bus_a.if_id_pc4_o !== 32'h2C) begin errors++; $display("FAIL mm_ifid_only act=%h/%h/%h exp=%h/%h/%h", bus_a.pc_o, bus_a.if_id_instr_o, bus_a.if_id_pc4_o, 32'h28, mem(32'h28), 32'h2C); end
    checks++; if (bus_a.stall_cnt_o !== 16'd2) begin errors++; $display("FAIL mm_stall_cnt act=%0d exp=2", bus_a.stall_cnt_o); end
  endtask

  task automatic test_reset_mid_stall();
    bus_a.pc_write_i = 1'b1; bus_a.if_id_write_i = 1'b1;
    step();
    step();
    bus_a.pc_write_i = 1'b0; bus_a.if_id_write_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    checks++; if (bus_a.pc_o !== 32'h30 || bus_a.stall_cnt_o !== 16'd5) begin errors++; $display("FAIL rms_setup act=%h/%0d exp=%h/5", bus_a.pc_o, bus_a.stall_cnt_o, 32'h30); end
    rst_a = 1'b0;
    step();
    checks++; if (bus_a.pc_o !== 32'h0 || bus_a.if_id_valid_o !== 1'b0) begin errors++; $display("FAIL rms_state act=%h/%b exp=0/0", bus_a.pc_o, bus_a.if_id_valid_o); end
    checks++; if (bus_a.stall_cnt_o !== 16'd0 || bus_a.flush_cnt_o !== 16'd0) begin errors++; $display("FAIL rms_cnt act=%0d/%0d exp=0/0", bus_a.stall_cnt_o, bus_a.flush_cnt_o); end
    rst_a = 1'b1;
  endtask

  task automatic test_wrap();
    rst_b = 1'b0;
    step();
    checks++; if (bus_b.pc_o !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_reset act=%h exp=%h", bus_b.pc_o, 32'hFFFF_FFF8); end
    rst_b = 1'b1;
    step();
    checks++; if (bus_b.pc_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc1 act=%h exp=%h", bus_b.pc_o, 32'hFFFF_FFFC); end
    step();
    checks++; if (bus_b.pc_o !== 32'h0) begin errors++; $display("FAIL wrap_pc2 act=%h exp=%h", bus_b.pc_o, 32'h0); end
    checks++; if (bus_b.if_id_pc4_o !== 32'h0 || bus_b.if_id_instr_o !== mem(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_ifid act=%h/%h exp=%h/%h", bus_b.if_id_pc4_o, bus_b.if_id_instr_o, 32'h0, mem(32'hFFFF_FFFC)); end
  endtask

  task automatic test_saturation();
    logic [3:0] exp_cnt;
    bus_b.pc_write_i = 1'b0; bus_b.if_id_write_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      exp_cnt = (i + 1 > 15) ? 4'hF : 4'(i + 1);
      checks++; if (bus_b.stall_cnt_o !== exp_cnt) begin errors++; $display("FAIL sat_cnt%0d act=%h exp=%h", i, bus_b.stall_cnt_o, exp_cnt); end
    end
    checks++; if (bus_b.pc_o !== 32'h0 || bus_b.flush_cnt_o !== 4'h0) begin errors++; $display("FAIL sat_hold act=%h/%h exp=0/0", bus_b.pc_o, bus_b.flush_cnt_o); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_b = 1'b0;
    bus_b.pc_write_i = 1'b1; bus_b.if_id_write_i = 1'b1;
    bus_b.flush_i = 1'b0; bus_b.branch_target_i = 32'h0;
    test_reset();
    test_flow();
    test_stall();
    test_branch();
    test_flush_over_stall();
    test_mismatched_enables();
    test_reset_mid_stall();
    test_wrap();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
